// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: RV32I opcodes, the NOP encoding,
// fetch FSM state encodings and a PC alignment helper.
package fetch_unit_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = {12'd0, 5'd0, 3'd0, 5'd0, OPC_OP_IMM};

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: icache request/response handshake, downstream control inputs and the
// instruction presented to decode.
interface fetch_unit_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_valid;

  modport master (
    output icache_req, icache_addr, instr, instr_pc, instr_pc_plus4, instr_valid,
    input  icache_ready, icache_rdata, stall, redirect, redirect_target
  );

  modport slave (
    input  icache_req, icache_addr, instr, instr_pc, instr_pc_plus4, instr_valid,
    output icache_ready, icache_rdata, stall, redirect, redirect_target
  );
endinterface

// File: rtl/fetch_skid_q.sv
// Two-entry {pc, instr} queue: head register drives the fetch outputs, skid register absorbs
// one extra word while downstream is stalled.
module fetch_skid_q #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic [31:0] i_push_pc,
  input  logic [31:0] i_push_instr,
  input  logic        i_pop,
  input  logic        i_flush,
  output logic [1:0]  o_count,
  output logic        o_valid,
  output logic [31:0] o_head_pc,
  output logic [31:0] o_head_instr
);

  logic [31:0] r_head_pc, r_head_instr, r_skid_pc, r_skid_instr;
  logic [31:0] w_head_pc_d, w_head_instr_d, w_skid_pc_d, w_skid_instr_d;
  logic [1:0]  r_count, w_count_d;
  logic        r_valid;

  always_comb begin
    w_head_pc_d    = r_head_pc;
    w_head_instr_d = r_head_instr;
    w_skid_pc_d    = r_skid_pc;
    w_skid_instr_d = r_skid_instr;
    w_count_d      = r_count;
    if (i_flush) begin
      w_count_d      = 2'd0;
      w_head_instr_d = NOP_INSTR;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_head_pc_d    = i_push_pc;
            w_head_instr_d = i_push_instr;
            w_count_d      = 2'd1;
          end else begin
            w_skid_pc_d    = i_push_pc;
            w_skid_instr_d = i_push_instr;
            w_count_d      = 2'd2;
          end
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            w_head_pc_d    = r_skid_pc;
            w_head_instr_d = r_skid_instr;
            w_count_d      = 2'd1;
          end else begin
            w_head_instr_d = NOP_INSTR;
            w_count_d      = 2'd0;
          end
        end
        2'b11: begin
          // Skid advances into head while the new word lands behind it: order kept, no bubble.
          if (r_count == 2'd2) begin
            w_head_pc_d    = r_skid_pc;
            w_head_instr_d = r_skid_instr;
            w_skid_pc_d    = i_push_pc;
            w_skid_instr_d = i_push_instr;
          end else begin
            w_head_pc_d    = i_push_pc;
            w_head_instr_d = i_push_instr;
            w_count_d      = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_pc    <= RESET_PC;
      r_head_instr <= NOP_INSTR;
      r_skid_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
      r_count      <= 2'd0;
      r_valid      <= 1'b0;
    end else begin
      r_head_pc    <= w_head_pc_d;
      r_head_instr <= w_head_instr_d;
      r_skid_pc    <= w_skid_pc_d;
      r_skid_instr <= w_skid_instr_d;
      r_count      <= w_count_d;
      r_valid      <= (w_count_d != 2'd0);
    end
  end

  assign o_count      = r_count;
  assign o_valid      = r_valid;
  assign o_head_pc    = r_head_pc;
  assign o_head_instr = r_head_instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, icache req/ready handshake FSM, redirect handling
// and a two-entry output queue feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  import fetch_unit_pkg::*;

  fetch_state_e r_state, w_state_d;
  logic [31:0]  r_pc, w_pc_d, r_tgt, w_tgt_d;
  logic [1:0]   w_count;
  logic         w_valid, w_req, w_consume, w_redir, w_accept;
  logic [31:0]  w_head_pc, w_head_instr;

  // Decoded from registers only; once raised it stays up until icache_ready.
  assign w_req     = (r_state == S_DROP) || ((r_state == S_RUN) && (w_count != 2'd2));
  assign w_consume = w_valid & ~bus.stall;
  assign w_redir   = w_consume & bus.redirect;
  assign w_accept  = (r_state == S_RUN) & w_req & bus.icache_ready;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_tgt_d   = r_tgt;
    unique case (r_state)
      S_BOOT: w_state_d = S_RUN;
      S_RUN: begin
        if (w_redir) begin
          if (w_req && !bus.icache_ready) begin
            // Pending request cannot be withdrawn: hold old pc, park the target.
            w_state_d = S_DROP;
            w_tgt_d   = align_word(bus.redirect_target);
          end else begin
            w_pc_d = align_word(bus.redirect_target);
          end
        end else if (w_accept) begin
          w_pc_d = r_pc + 32'd4;
        end
      end
      S_DROP: begin
        if (bus.icache_ready) begin
          w_pc_d    = r_tgt;
          w_state_d = S_RUN;
        end
      end
      default: w_state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_tgt   <= RESET_PC;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_tgt   <= w_tgt_d;
    end
  end

  fetch_skid_q #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_skid_q (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_accept & ~w_redir),
    .i_push_pc    (r_pc),
    .i_push_instr (bus.icache_rdata),
    .i_pop        (w_consume & ~w_redir),
    .i_flush      (w_redir),
    .o_count      (w_count),
    .o_valid      (w_valid),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr)
  );

  assign bus.icache_req     = w_req;
  assign bus.icache_addr    = r_pc;
  assign bus.instr          = w_head_instr;
  assign bus.instr_pc       = w_head_pc;
  assign bus.instr_pc_plus4 = w_head_pc + 32'd4;
  assign bus.instr_valid    = w_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, icache wait states, stall, redirects with and
// without a pending request, async reset and PC wrap.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_unit_if bus ();

  fetch_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Icache model: word content is a distinct function of its address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  assign bus.icache_rdata = word_of(bus.icache_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
    check({tag, "_pc"}, bus.instr_pc, pc);
    check({tag, "_instr"}, bus.instr, word_of(pc));
    check({tag, "_pc4"}, bus.instr_pc_plus4, pc + 32'd4);
  endtask

  initial begin
    bus.icache_ready    = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'd0;
    repeat (2) tick();

    // 1: reset state, boot cycle, streaming
    check("rst_req", {31'd0, bus.icache_req}, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, NOP);
    check("rst_pc", bus.instr_pc, 32'd0);
    rst_n = 1'b1;
    #1;
    check("boot_req", {31'd0, bus.icache_req}, 32'd0);
    tick();
    check("run_req", {31'd0, bus.icache_req}, 32'd1);
    check("run_addr", bus.icache_addr, 32'd0);
    check("run_valid", {31'd0, bus.instr_valid}, 32'd0);
    for (int n = 2; n <= 5; n++) begin
      tick();
      check_out("stream", 32'(4 * (n - 2)));
      check("stream_addr", bus.icache_addr, 32'(4 * (n - 1)));
    end

    // 2: icache wait states at 0x10
    bus.icache_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wait_req", {31'd0, bus.icache_req}, 32'd1);
      check("wait_addr", bus.icache_addr, 32'h10);
      check("wait_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    bus.icache_ready = 1'b1;
    tick();
    check_out("wait_done", 32'h10);
    check("wait_next_addr", bus.icache_addr, 32'h14);
    tick();
    check_out("wait_after", 32'h14);

    // 3: stall at 0x20; queue fills with 0x24 then requests stop
    repeat (3) tick();
    check_out("pre_stall", 32'h20);
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out("stall_frz", 32'h20);
      check("stall_req", {31'd0, bus.icache_req}, 32'd0);
      check("stall_addr", bus.icache_addr, 32'h28);
    end
    bus.stall = 1'b0;
    tick();
    check_out("rel0", 32'h24);
    check("rel0_req", {31'd0, bus.icache_req}, 32'd1);
    tick();
    check_out("rel1", 32'h28);
    tick();
    check_out("rel2", 32'h2C);

    // 4: redirect with same-cycle icache_ready
    repeat (5) tick();
    check_out("pre_redir", 32'h40);
    check("pre_redir_addr", bus.icache_addr, 32'h44);
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h103;
    tick();
    bus.redirect = 1'b0;
    check("redir_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("redir_instr", bus.instr, NOP);
    check("redir_addr", bus.icache_addr, 32'h100);
    check("redir_req", {31'd0, bus.icache_req}, 32'd1);
    tick();
    check_out("redir_tgt", 32'h100);

    // 5: redirect while request to 0x48 is pending
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h44;
    tick();
    bus.redirect = 1'b0;
    tick();
    check_out("pre_drop", 32'h44);
    check("pre_drop_addr", bus.icache_addr, 32'h48);
    bus.icache_ready    = 1'b0;
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h200;
    tick();
    bus.redirect = 1'b0;
    check("drop_valid0", {31'd0, bus.instr_valid}, 32'd0);
    check("drop_req0", {31'd0, bus.icache_req}, 32'd1);
    check("drop_addr0", bus.icache_addr, 32'h48);
    tick();
    check("drop_addr1", bus.icache_addr, 32'h48);
    check("drop_valid1", {31'd0, bus.instr_valid}, 32'd0);
    bus.icache_ready = 1'b1;
    tick();
    check("drop_valid2", {31'd0, bus.instr_valid}, 32'd0);
    check("drop_new_addr", bus.icache_addr, 32'h200);
    tick();
    check_out("drop_tgt", 32'h200);

    // 6: async reset with full queue, then mid-request, then pc wrap
    bus.stall = 1'b1;
    tick();
    check("full_req", {31'd0, bus.icache_req}, 32'd0);
    rst_n = 1'b0;
    #2;
    check("rst_full_req", {31'd0, bus.icache_req}, 32'd0);
    check("rst_full_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_full_instr", bus.instr, NOP);
    check("rst_full_pc", bus.instr_pc, 32'd0);
    bus.stall        = 1'b0;
    bus.icache_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mid_req", {31'd0, bus.icache_req}, 32'd1);
    check("mid_addr", bus.icache_addr, 32'd0);
    rst_n = 1'b0;
    #2;
    check("rst_mid_req", {31'd0, bus.icache_req}, 32'd0);
    check("rst_mid_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    rst_n            = 1'b1;
    bus.icache_ready = 1'b1;
    tick();
    tick();
    check_out("restart", 32'd0);
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'hFFFF_FFF8;
    tick();
    bus.redirect = 1'b0;
    check("wrap_addr0", bus.icache_addr, 32'hFFFF_FFF8);
    tick();
    check_out("wrap_a", 32'hFFFF_FFF8);
    tick();
    check_out("wrap_b", 32'hFFFF_FFFC);
    check("wrap_pc4", bus.instr_pc_plus4, 32'd0);
    check("wrap_addr1", bus.icache_addr, 32'd0);
    tick();
    check_out("wrap_c", 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
